// File: rtl/oct_play_buf.sv
// Ping-pong playback buffer: captures 512-sample overlap-add bursts at clk rate and
// replays them one sample per DIV clocks toward the serializer, with sticky overflow/underrun.
module oct_play_buf #(
   parameter int DEPTH = 512,
   parameter int DIV   = 1024,
   parameter int W     = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic signed [W-1:0] in_sample,
   input  logic                clr_flags,
   output logic                out_valid,
   output logic signed [W-1:0] out_sample,
   output logic                bank_free,
   output logic                overflow,
   output logic                underrun
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

   typedef enum logic [1:0] {
      PRIME  = 2'd0,
      PLAY   = 2'd1,
      STARVE = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic [AW-1:0]       wr_ptr, rd_ptr;
   logic                wr_bank, rd_bank;
   logic [1:0]          full, full_nxt;
   logic [CW-1:0]       cnt;
   logic                tick;
   logic                wr_en, wr_last, drop;
   logic                rd_en, rd_last, starve_tick;

   // Bank index is the address MSB, so each bank is one contiguous half of the RAM.
   logic signed [W-1:0] mem [0:2*DEPTH-1];

   assign tick        = (cnt == CW'(DIV-1));
   assign wr_en       = in_valid & ~full[wr_bank];
   assign wr_last     = wr_en & (wr_ptr == AW'(DEPTH-1));
   assign drop        = in_valid & full[wr_bank];
   assign rd_en       = (state == PLAY) & tick;
   assign rd_last     = rd_en & (rd_ptr == AW'(DEPTH-1));
   assign starve_tick = (state == STARVE) & tick;
   assign bank_free   = ~full[wr_bank];

   // Write completion and read drain always target different banks, so both apply.
   always_comb begin
      full_nxt = full;
      if (wr_last) full_nxt[wr_bank] = 1'b1;
      if (rd_last) full_nxt[rd_bank] = 1'b0;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         PRIME:   if (full[0]) state_nxt = PLAY;
         PLAY:    if (rd_last && !full_nxt[~rd_bank]) state_nxt = STARVE;
         STARVE:  if (full_nxt[rd_bank]) state_nxt = PLAY;
         default: state_nxt = PRIME;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[{wr_bank, wr_ptr}] <= in_sample;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= PRIME;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         wr_bank    <= 1'b0;
         rd_bank    <= 1'b0;
         full       <= '0;
         cnt        <= '0;
         out_valid  <= 1'b0;
         out_sample <= '0;
         overflow   <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         state <= state_nxt;
         full  <= full_nxt;
         cnt   <= tick ? '0 : cnt + 1'b1;

         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (wr_last) wr_bank <= ~wr_bank;
         end

         if (rd_en) begin
            rd_ptr <= rd_ptr + 1'b1;
            if (rd_last) rd_bank <= ~rd_bank;
         end

         // Output stage: RAM read lands one cycle after the tick, together with out_valid.
         out_valid <= rd_en | starve_tick;
         if (rd_en)
            out_sample <= mem[{rd_bank, rd_ptr}];
         else if (starve_tick)
            out_sample <= '0;

         if (drop)
            overflow <= 1'b1;
         else if (clr_flags)
            overflow <= 1'b0;

         if (starve_tick)
            underrun <= 1'b1;
         else if (clr_flags)
            underrun <= 1'b0;
      end
   end

endmodule
